usr_ctrl: RTL and testbench

USR_CTRL -- requirements
Module: usr_ctrl

---
 rtl/usr_pkg.sv | 24 ++
 rtl/usr.sv | 28 ++
 rtl/usr_ctrl.sv | 127 ++++++++++++
 tb/tb_usr_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register and its controller.
package usr_pkg;

    // USR mode select
    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_SHR  = 2'b01;
    localparam logic [1:0] S_SHL  = 2'b10;
    localparam logic [1:0] S_LOAD = 2'b11;

    // Command opcodes
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/usr.sv
// 4-bit universal shift register: hold, shift right, shift left, parallel load.
module usr
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] s,
    input  logic [3:0] I,
    input  logic       SINR,
    input  logic       SINL,
    output logic [3:0] O
);

    // Register update selected by the mode input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            O <= 4'b0000;
        end else begin
            case (s)
                S_SHR:   O <= {SINR, O[3:1]};
                S_SHL:   O <= {O[2:0], SINL};
                S_LOAD:  O <= I;
                default: O <= O;
            endcase
        end
    end

endmodule

// File: rtl/usr_ctrl.sv
// Command sequencer for the USR: accepts LOAD/SHR/SHL/ROR commands and
// steps the register through the requested number of shift cycles.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a command, cmd_ready high, USR holds
//   ST_LOAD  | one cycle of parallel load from the latched data
//   ST_SHIFT | shifting once per cycle until the remaining count reaches 0
//   ST_DONE  | one-cycle done pulse, no command accepted
module usr_ctrl
    import usr_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [3:0]       cmd_data,
    input  logic             cmd_fill,
    output logic             busy,
    output logic             done,
    output logic [3:0]       q
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_data;
    logic             r_fill;

    logic [1:0]       w_s;
    logic [3:0]       w_i;
    logic             w_sinr;
    logic             w_sinl;
    logic [3:0]       w_o;

    // Sequencer: latch the command in IDLE, then walk LOAD/SHIFT -> DONE -> IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= 2'b00;
            r_cnt   <= CNT_ZERO;
            r_data  <= 4'b0000;
            r_fill  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op   <= cmd_op;
                        r_cnt  <= cmd_cnt;
                        r_data <= cmd_data;
                        r_fill <= cmd_fill;
                        if (cmd_op == OP_LOAD)
                            r_state <= ST_LOAD;
                        else if (cmd_cnt == CNT_ZERO)
                            r_state <= ST_DONE;
                        else
                            r_state <= ST_SHIFT;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_DONE;
                end
                ST_SHIFT: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE)
                        r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // USR controls decoded only from registered state and latched fields;
    // ROR feeds the register's own LSB back into SINR.
    always_comb begin
        w_s    = S_HOLD;
        w_i    = 4'b0000;
        w_sinr = 1'b0;
        w_sinl = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_s = S_LOAD;
                w_i = r_data;
            end
            ST_SHIFT: begin
                if (r_op == OP_SHL) begin
                    w_s    = S_SHL;
                    w_sinl = r_fill;
                end else begin
                    w_s    = S_SHR;
                    w_sinr = (r_op == OP_ROR) ? w_o[0] : r_fill;
                end
            end
            default: begin
                w_s = S_HOLD;
            end
        endcase
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign q         = w_o;

    usr u_usr (
        .clk   (clk),
        .reset (reset),
        .s     (w_s),
        .I     (w_i),
        .SINR  (w_sinr),
        .SINL  (w_sinl),
        .O     (w_o)
    );

endmodule

// File: tb/tb_usr_ctrl.sv
// Bench for usr_ctrl: directed scenarios plus randomized commands with
// noise on the command inputs while busy, checked against a value model.
module tb_usr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_cnt;
    logic [3:0] cmd_data;
    logic       cmd_fill;
    logic       busy;
    logic       done;
    logic [3:0] q;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] mq;   // model of q

    usr_ctrl #(.CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .cmd_fill  (cmd_fill),
        .busy      (busy),
        .done      (done),
        .q         (q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One shift step as the operation is defined on the 4-bit value
    function automatic logic [3:0] step(input logic [1:0] op, input logic [3:0] v, input logic fill);
        case (op)
            2'b01:   return {fill, v[3:1]};
            2'b10:   return {v[2:0], fill};
            2'b11:   return {v[0], v[3:1]};
            default: return v;
        endcase
    endfunction

    // Issue one command, then follow it cycle by cycle to completion
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                          input logic fill, input bit noise);
        int exp_len;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = data;
        cmd_fill  = fill;
        chk("ready_idle", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        exp_len = (op == 2'b00) ? 2 : int'(cnt) + 1;
        for (int k = 1; k <= exp_len; k++) begin
            @(negedge clk);
            if (noise) begin
                cmd_valid = 1'($urandom);
                cmd_op    = 2'($urandom);
                cmd_cnt   = 3'($urandom);
                cmd_data  = 4'($urandom);
                cmd_fill  = 1'($urandom);
            end
            if (op == 2'b00) begin
                if (k == 2) mq = data;
            end else if (k >= 2) begin
                mq = step(op, mq, fill);
            end
            chk("q_cycle", q, mq);
            chk("busy", busy, 1);
            chk("ready_busy", cmd_ready, 0);
            chk("done_pulse", done, (k == exp_len) ? 1 : 0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("done_end", done, 0);
        chk("busy_end", busy, 0);
        chk("ready_end", cmd_ready, 1);
        chk("q_end", q, mq);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_cnt   = 3'd0;
        cmd_data  = 4'd0;
        cmd_fill  = 1'b0;
        mq        = 4'b0000;
        #12;
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", cmd_ready, 1);

        // Directed sequences
        do_cmd(2'b00, 3'd0, 4'b1011, 1'b0, 0);
        chk("load_1011", q, 4'b1011);
        do_cmd(2'b01, 3'd2, 4'b0000, 1'b1, 0);
        chk("shr2", q, 4'b1110);
        do_cmd(2'b00, 3'd0, 4'b0001, 1'b0, 0);
        do_cmd(2'b10, 3'd3, 4'b0000, 1'b0, 0);
        chk("shl3", q, 4'b1000);
        do_cmd(2'b11, 3'd4, 4'b0000, 1'b0, 0);
        chk("ror4", q, 4'b1000);
        do_cmd(2'b11, 3'd1, 4'b0000, 1'b0, 0);
        chk("ror1", q, 4'b0100);
        do_cmd(2'b01, 3'd0, 4'b1111, 1'b1, 0);
        chk("shr0", q, 4'b0100);
        do_cmd(2'b00, 3'd0, 4'b0001, 1'b0, 0);
        do_cmd(2'b10, 3'd7, 4'b0000, 1'b1, 0);
        chk("shl7", q, 4'b1111);

        // Reset in the 3rd cycle of SHR cnt=5
        do_cmd(2'b00, 3'd0, 4'b1011, 1'b0, 0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_cnt   = 3'd5;
        cmd_fill  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        mq = 4'b0000;
        chk("abort_q", q, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_nodone", done, 0);
        end
        reset = 1'b0;
        #1;
        chk("abort_ready", cmd_ready, 1);
        @(negedge clk);
        chk("abort_nodone2", done, 0);
        chk("abort_q2", q, 0);
        do_cmd(2'b00, 3'd0, 4'b0110, 1'b0, 0);
        chk("load_0110", q, 4'b0110);

        // Randomized commands with noise on the inputs while busy
        for (int r = 0; r < 30; r++) begin
            do_cmd(2'($urandom), 3'($urandom_range(0, 7)), 4'($urandom), 1'($urandom), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
